// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array input feeder.
package systolic_pkg;
    localparam int N_DEF     = 4;
    localparam int DW_DEF    = 32;
    localparam int DRAIN_CYC = 2;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    // Cycles needed for the last skewed element to enter corner PE(N-1,N-1).
    function automatic int stream_len(input int n);
        return 3 * n - 2;
    endfunction
endpackage

// File: rtl/systolic_feeder_if.sv
// Load port plus array-edge outputs of the feeder; master = tile source, slave = feeder.
interface systolic_feeder_if #(
    parameter int N  = 4,
    parameter int DW = 32
);
    logic            load_valid;
    logic            load_ready;
    logic            load_sel;
    logic [N*DW-1:0] load_data;
    logic            start;
    logic            busy;
    logic            done;
    logic            tile_start;
    logic            edge_valid;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;

    modport master (
        output load_valid, load_sel, load_data, start,
        input  load_ready, busy, done, tile_start, edge_valid, a_edge, b_edge
    );
    modport slave (
        input  load_valid, load_sel, load_data, start,
        output load_ready, busy, done, tile_start, edge_valid, a_edge, b_edge
    );
endinterface

// File: rtl/skew_lane.sv
// One edge lane: picks buffered element (step - LANE), zero outside the window, registered.
module skew_lane #(
    parameter int DW   = 32,
    parameter int N    = 4,
    parameter int LANE = 0,
    parameter int KW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_vld,
    input  logic [KW-1:0]        step,
    input  logic [N-1:0][DW-1:0] vec,
    output logic [DW-1:0]        lane_q
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [KW-1:0] off;
    logic          in_rng;
    logic [DW-1:0] sel;

    always_comb begin
        off    = step - KW'(LANE);
        in_rng = step_vld && (step >= KW'(LANE)) && (off < KW'(N));
        sel    = in_rng ? vec[off[IW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lane_q <= '0;
        else        lane_q <= sel;
    end
endmodule

// File: rtl/systolic_feeder.sv
// Buffers one A/B tile and streams it diagonally skewed into an N x N systolic array.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF
) (
    input logic               clk,
    input logic               rst_n,
    systolic_feeder_if.slave  bus
);
    localparam int S  = stream_len(N);
    localparam int KW = $clog2(3 * N);
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t                       state;
    logic [KW-1:0]                k;
    logic [CW-1:0]                a_cnt, b_cnt;
    logic [N-1:0][N-1:0][DW-1:0]  a_buf, b_buf;
    logic [N-1:0][DW-1:0]         ld_vec, a_q, b_q;
    logic                         load_ready, load_ok, start_ok, step_vld;
    logic [KW-1:0]                step;
    logic                         busy_q, done_q, tile_start_q, edge_valid_q;

    assign ld_vec = bus.load_data;

    // step/step_vld describe the cycle being entered, so lane registers line up with k.
    always_comb begin
        load_ready = (state == IDLE) && (bus.load_sel ? (b_cnt < CW'(N)) : (a_cnt < CW'(N)));
        load_ok    = bus.load_valid && load_ready;
        start_ok   = (state == IDLE) && bus.start && (a_cnt == CW'(N)) && (b_cnt == CW'(N));
        step_vld   = 1'b0;
        step       = '0;
        if (start_ok) begin
            step_vld = 1'b1;
        end else if (state == STREAM && k != KW'(S - 1)) begin
            step_vld = 1'b1;
            step     = k + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (load_ok) begin
            if (bus.load_sel) b_buf[b_cnt[IW-1:0]] <= ld_vec;
            else              a_buf[a_cnt[IW-1:0]] <= ld_vec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k            <= '0;
            a_cnt        <= '0;
            b_cnt        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tile_start_q <= 1'b0;
            edge_valid_q <= 1'b0;
        end else begin
            tile_start_q <= start_ok;
            edge_valid_q <= step_vld;
            done_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        if (bus.load_sel) b_cnt <= b_cnt + 1'b1;
                        else              a_cnt <= a_cnt + 1'b1;
                    end
                    if (start_ok) begin
                        state  <= STREAM;
                        k      <= '0;
                        busy_q <= 1'b1;
                    end
                end
                STREAM: begin
                    if (k == KW'(S - 1)) begin
                        state <= DRAIN;
                        k     <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    done_q <= (k == KW'(DRAIN_CYC - 2));
                    if (k == KW'(DRAIN_CYC - 1)) begin
                        state  <= IDLE;
                        k      <= '0;
                        busy_q <= 1'b0;
                        a_cnt  <= '0;
                        b_cnt  <= '0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(.DW(DW), .N(N), .LANE(i), .KW(KW)) u_a (
            .clk(clk), .rst_n(rst_n), .step_vld(step_vld), .step(step),
            .vec(a_buf[i]), .lane_q(a_q[i])
        );
        skew_lane #(.DW(DW), .N(N), .LANE(i), .KW(KW)) u_b (
            .clk(clk), .rst_n(rst_n), .step_vld(step_vld), .step(step),
            .vec(b_buf[i]), .lane_q(b_q[i])
        );
    end

    assign bus.load_ready = load_ready;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.tile_start = tile_start_q;
    assign bus.edge_valid = edge_valid_q;
    assign bus.a_edge     = a_q;
    assign bus.b_edge     = b_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench: N=2 feeder with a 2x2 MAC array model, plus an N=4 feeder for skew sweeps.
module tb_systolic_feeder;
    import systolic_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    systolic_feeder_if #(.N(2), .DW(32)) f2 ();
    systolic_feeder_if #(.N(4), .DW(32)) f4 ();

    systolic_feeder #(.N(2), .DW(32)) u2 (.clk(clk), .rst_n(rst_n), .bus(f2.slave));
    systolic_feeder #(.N(4), .DW(32)) u4 (.clk(clk), .rst_n(rst_n), .bus(f4.slave));

    // 2x2 output-stationary MAC array fed by u2.
    logic [31:0] ain [2][2];
    logic [31:0] bin [2][2];
    logic [31:0] pa [2][2];
    logic [31:0] pb [2][2];
    logic [31:0] pc [2][2];
    logic [31:0] po [2][2];
    assign ain[0][0] = f2.a_edge[31:0];
    assign ain[1][0] = f2.a_edge[63:32];
    assign ain[0][1] = pa[0][0];
    assign ain[1][1] = pa[1][0];
    assign bin[0][0] = f2.b_edge[31:0];
    assign bin[0][1] = f2.b_edge[63:32];
    assign bin[1][0] = pb[0][0];
    assign bin[1][1] = pb[0][1];

    always_ff @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (!rst_n) begin
                    pa[i][j] <= '0; pb[i][j] <= '0; pc[i][j] <= '0; po[i][j] <= '0;
                end else begin
                    pa[i][j] <= ain[i][j];
                    pb[i][j] <= bin[i][j];
                    pc[i][j] <= pc[i][j] + ain[i][j] * bin[i][j];
                    po[i][j] <= pc[i][j];
                end
    end

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ev;
        logic        ts;
        logic        bz;
        logic        dn;
    } vec_t;
    vec_t tbl [7];

    logic [31:0] ma [4][4];
    logic [31:0] mb [4][4];

    task automatic note(input bit ok, input string msg);
        nvec++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s", msg);
        end
    endtask
    task automatic chkb(input string nm, input logic act, input logic exp);
        note(act === exp, $sformatf("%s: got %0b, want %0b", nm, act, exp));
    endtask
    task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
        note(act === exp, $sformatf("%s: got %0h, want %0h", nm, act, exp));
    endtask
    task automatic chki(input string nm, input int act, input int exp);
        note(act == exp, $sformatf("%s: got %0d, want %0d", nm, act, exp));
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic ld2(input logic sel, input logic [31:0] e0, input logic [31:0] e1, input logic rdy);
        f2.load_valid = 1'b1; f2.load_sel = sel; f2.load_data = {e1, e0};
        @(negedge clk);
        chkb($sformatf("ld2 ready sel=%0b", sel), f2.load_ready, rdy);
        @(posedge clk); #1;
        f2.load_valid = 1'b0;
    endtask
    task automatic ld4(input logic sel, input logic [127:0] d);
        f4.load_valid = 1'b1; f4.load_sel = sel; f4.load_data = d;
        @(negedge clk);
        chkb("ld4 ready", f4.load_ready, 1'b1);
        @(posedge clk); #1;
        f4.load_valid = 1'b0;
    endtask
    task automatic load_tile2();
        ld2(1'b0, 32'd1, 32'd2, 1'b1);
        ld2(1'b0, 32'd3, 32'd4, 1'b1);
        ld2(1'b1, 32'd5, 32'd7, 1'b1);
        ld2(1'b1, 32'd6, 32'd8, 1'b1);
    endtask

    function automatic logic [127:0] exp_a(input int k);
        logic [127:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (k - i >= 0 && k - i < 4) r[i*32 +: 32] = ma[i][k-i];
        return r;
    endfunction
    function automatic logic [127:0] exp_b(input int k);
        logic [127:0] r = '0;
        for (int j = 0; j < 4; j++)
            if (k - j >= 0 && k - j < 4) r[j*32 +: 32] = mb[k-j][j];
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic seen;
        localparam int S4 = stream_len(4);

        f2.load_valid = 1'b0; f2.load_sel = 1'b0; f2.load_data = '0; f2.start = 1'b0;
        f4.load_valid = 1'b0; f4.load_sel = 1'b0; f4.load_data = '0; f4.start = 1'b0;

        tbl[0] = '{{32'd0, 32'd1}, {32'd0, 32'd5}, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{{32'd3, 32'd2}, {32'd6, 32'd7}, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{{32'd4, 32'd0}, {32'd8, 32'd0}, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{64'd0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkb("rst busy", f2.busy, 1'b0);
        chkb("rst done", f2.done, 1'b0);
        chkb("rst edge_valid", f2.edge_valid, 1'b0);
        chkb("rst tile_start", f2.tile_start, 1'b0);
        chkv("rst a_edge", 128'(f2.a_edge), 128'd0);
        chkv("rst b_edge", 128'(f2.b_edge), 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chkb("rst ready after release", f2.load_ready, 1'b1);
        @(posedge clk); #1;

        // basic tile, overflow row refused, loads refused while streaming
        load_tile2();
        ld2(1'b0, 32'd9, 32'd9, 1'b0);
        f2.start = 1'b1;
        @(posedge clk); #1;
        f2.start = 1'b0;
        f2.load_valid = 1'b1; f2.load_sel = 1'b0; f2.load_data = {32'd99, 32'd99};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chkv($sformatf("t1 c%0d a_edge", c), 128'(f2.a_edge), 128'(tbl[c].a));
            chkv($sformatf("t1 c%0d b_edge", c), 128'(f2.b_edge), 128'(tbl[c].b));
            chkb($sformatf("t1 c%0d edge_valid", c), f2.edge_valid, tbl[c].ev);
            chkb($sformatf("t1 c%0d tile_start", c), f2.tile_start, tbl[c].ts);
            chkb($sformatf("t1 c%0d busy", c), f2.busy, tbl[c].bz);
            chkb($sformatf("t1 c%0d done", c), f2.done, tbl[c].dn);
            if (c < 4) chkb($sformatf("t1 c%0d ready in stream", c), f2.load_ready, 1'b0);
            if (c == 5) begin
                chkv("t2 c_out00", 128'(po[0][0]), 128'd19);
                chkv("t2 c_out01", 128'(po[0][1]), 128'd22);
                chkv("t2 c_out10", 128'(po[1][0]), 128'd43);
                chkv("t2 c_out11", 128'(po[1][1]), 128'd50);
            end
            @(posedge clk); #1;
            if (c == 3) f2.load_valid = 1'b0;
        end

        // start ignored with incomplete tile, including load+start in one cycle
        ld2(1'b0, 32'd1, 32'd2, 1'b1);
        ld2(1'b0, 32'd3, 32'd4, 1'b1);
        ld2(1'b1, 32'd5, 32'd7, 1'b1);
        f2.start = 1'b1;
        @(posedge clk); #1;
        f2.start = 1'b0;
        @(negedge clk);
        chkb("t3 early start busy", f2.busy, 1'b0);
        chkb("t3 early start edge_valid", f2.edge_valid, 1'b0);
        @(posedge clk); #1;
        f2.load_valid = 1'b1; f2.load_sel = 1'b1; f2.load_data = {32'd8, 32'd6}; f2.start = 1'b1;
        @(negedge clk);
        chkb("t3 last column ready", f2.load_ready, 1'b1);
        @(posedge clk); #1;
        f2.load_valid = 1'b0; f2.start = 1'b0;
        @(negedge clk);
        chkb("t3 load+start busy", f2.busy, 1'b0);
        chkb("t3 b full ready", f2.load_ready, 1'b0);
        @(posedge clk); #1;
        f2.start = 1'b1;
        @(posedge clk); #1;
        f2.start = 1'b0;
        @(negedge clk);
        chkb("t3 run busy", f2.busy, 1'b1);
        chkb("t3 run tile_start", f2.tile_start, 1'b1);
        chkv("t3 run a_edge", 128'(f2.a_edge), 128'({32'd0, 32'd1}));
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (f2.done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chki("t3 done cycle after first edge", lat, 5);
        @(negedge clk);
        chkb("t3 done single pulse", f2.done, 1'b0);
        chkb("t3 busy cleared", f2.busy, 1'b0);
        @(posedge clk); #1;

        // reset in the middle of a stream
        load_tile2();
        f2.start = 1'b1;
        @(posedge clk); #1;
        f2.start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chkb("t5 k1 edge_valid", f2.edge_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chkb("t5 abort busy", f2.busy, 1'b0);
        chkb("t5 abort edge_valid", f2.edge_valid, 1'b0);
        chkv("t5 abort a_edge", 128'(f2.a_edge), 128'd0);
        chkv("t5 abort b_edge", 128'(f2.b_edge), 128'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | f2.done;
        end
        chkb("t5 no done during reset", seen, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        f2.load_sel = 1'b0;
        @(negedge clk);
        chkb("t5 ready A after release", f2.load_ready, 1'b1);
        f2.load_sel = 1'b1;
        #1;
        chkb("t5 ready B after release", f2.load_ready, 1'b1);
        @(posedge clk); #1;
        f2.start = 1'b1;
        @(posedge clk); #1;
        f2.start = 1'b0;
        @(negedge clk);
        chkb("t5 tile lost start ignored", f2.busy, 1'b0);
        @(posedge clk); #1;

        // N=4 random tiles, reset between runs
        for (int run = 0; run < 2; run++) begin
            if (run == 1) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ma[i][j] = $urandom;
                    mb[i][j] = $urandom;
                end
            for (int i = 0; i < 4; i++) ld4(1'b0, {ma[i][3], ma[i][2], ma[i][1], ma[i][0]});
            for (int j = 0; j < 4; j++) ld4(1'b1, {mb[3][j], mb[2][j], mb[1][j], mb[0][j]});
            f4.start = 1'b1;
            @(posedge clk); #1;
            f4.start = 1'b0;
            for (int c = 0; c < S4 + 3; c++) begin
                @(negedge clk);
                chkv($sformatf("t6 r%0d c%0d a_edge", run, c), f4.a_edge, exp_a(c < S4 ? c : -1));
                chkv($sformatf("t6 r%0d c%0d b_edge", run, c), f4.b_edge, exp_b(c < S4 ? c : -1));
                chkb($sformatf("t6 r%0d c%0d edge_valid", run, c), f4.edge_valid, c < S4);
                chkb($sformatf("t6 r%0d c%0d tile_start", run, c), f4.tile_start, c == 0);
                chkb($sformatf("t6 r%0d c%0d done", run, c), f4.done, c == S4 + 1);
                chkb($sformatf("t6 r%0d c%0d busy", run, c), f4.busy, c <= S4 + 1);
                @(posedge clk); #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
